// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, drives the data memory for a single
// ACCESS cycle and returns extended load data. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
  parameter int XLEN   = 64,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_base,
  input  logic [XLEN-1:0]   req_offset,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_dataw,
  output logic [1:0]        mem_word,
  output logic              mem_rw,
  input  logic [XLEN-1:0]   mem_datar
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]      state;
  logic [2:0]      f3_q;
  logic            store_q;
  logic            range_q;
  logic [XLEN-1:0] ea_nxt;
  logic            f3_err, align_err, err;
  logic [XLEN-1:0] ld_data;

  assign ea_nxt     = req_base + req_offset;
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  // mem_addr already holds ea's low bits during ACCESS, so alignment is judged from it
  assign f3_err = store_q ? f3_q[2] : (f3_q == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    align_err = 1'b0;
    case (f3_q[1:0])
      2'b01:   align_err = mem_addr[0];
      2'b10:   align_err = |mem_addr[1:0];
      2'b11:   align_err = |mem_addr[2:0];
      default: align_err = 1'b0;
    endcase
  end
`else
  assign align_err = 1'b0;
`endif
  assign err = range_q | f3_err | align_err;

  // Gated by rst combinationally so a reset edge never coincides with a write
  assign mem_rw = (state == S_ACCESS) & store_q & ~err & ~rst;

  always_comb begin
    ld_data = '0;
    case (f3_q)
      3'b000:  ld_data = {{(XLEN-8){mem_datar[7]}},   mem_datar[7:0]};
      3'b001:  ld_data = {{(XLEN-16){mem_datar[15]}}, mem_datar[15:0]};
      3'b010:  ld_data = {{(XLEN-32){mem_datar[31]}}, mem_datar[31:0]};
      3'b011:  ld_data = mem_datar;
      3'b100:  ld_data = {{(XLEN-8){1'b0}},  mem_datar[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, mem_datar[15:0]};
      3'b110:  ld_data = {{(XLEN-32){1'b0}}, mem_datar[31:0]};
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      f3_q       <= '0;
      store_q    <= 1'b0;
      range_q    <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_word   <= '0;
      mem_dataw  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          f3_q      <= req_funct3;
          store_q   <= req_store;
          range_q   <= |ea_nxt[XLEN-1:MEM_AW];
          mem_addr  <= ea_nxt[MEM_AW-1:0];
          mem_word  <= req_funct3[1:0];
          mem_dataw <= req_wdata;
          state     <= S_ACCESS;
        end
        S_ACCESS: begin
          resp_err   <= err;
          resp_rdata <= (err || store_q) ? '0 : ld_data;
          state      <= S_RESP;
        end
        S_RESP: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, hand-written reset-abort sequence and
// randomized traffic against a byte-array reference model, with a modelled data memory.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_base, req_offset, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic [11:0] mem_addr;
  logic [63:0] mem_dataw, mem_datar;
  logic [1:0]  mem_word;
  logic        mem_rw;

  lsu_ctrl #(.XLEN(64), .MEM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_dataw(mem_dataw), .mem_word(mem_word),
    .mem_rw(mem_rw), .mem_datar(mem_datar)
  );

  always #5 clk = ~clk;

  // Data memory: combinational little-endian read, wraps at 4 KiB
  logic [7:0] mem [0:4095];
  logic       mem_clr;
  always_comb begin
    mem_datar = '0;
    for (int i = 0; i < 8; i++) mem_datar[8*i +: 8] = mem[12'(mem_addr + 12'(i))];
  end
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_rw) begin
      for (int i = 0; i < (1 << mem_word); i++) mem[12'(mem_addr + 12'(i))] <= mem_dataw[8*i +: 8];
    end
  end

  logic [7:0] ref_mem [0:4095];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: effective address, error rules and extension straight from the access semantics
  task automatic model(input logic st, input logic [2:0] f3, input logic [63:0] base, off, wd,
                       output logic [63:0] rd, output logic err, output logic wr, output logic [63:0] ea);
    int n;
    logic [63:0] v;
    ea  = base + off;
    n   = 1 << f3[1:0];
    err = (ea >> 12) != 0;
    if (st && f3[2]) err = 1'b1;
    if (!st && f3 == 3'b111) err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((ea % 64'(n)) != 0) err = 1'b1;
`endif
    wr = st && !err;
    rd = '0;
    if (wr)
      for (int i = 0; i < n; i++) ref_mem[int'((ea + 64'(i)) & 64'hFFF)] = wd[8*i +: 8];
    if (!st && !err) begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 64'(ref_mem[int'((ea + 64'(i)) & 64'hFFF)]) << (8*i);
      if (!f3[2] && n < 8 && v[8*n-1]) v |= ~64'd0 << (8*n);
      rd = v;
    end
  endtask

  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [63:0] base, off, wd,
                        input int hold, output logic [63:0] d_rd, output logic d_err,
                        output logic [63:0] m_rd, output logic m_err);
    logic wr;
    logic [63:0] ea;
    model(st, f3, base, off, wd, m_rd, m_err, wr, ea);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd;
    @(posedge clk); @(negedge clk);
    req_valid = 0;
    chk("access_mem_rw", mem_rw, wr);
    chk("access_mem_addr", mem_addr, ea[11:0]);
    chk("access_mem_word", mem_word, f3[1:0]);
    if (wr) chk("access_mem_dataw", mem_dataw, wd);
    chk("access_req_ready", req_ready, 0);
    chk("access_resp_valid", resp_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("resp_valid_n2", resp_valid, 1);
    chk("resp_mem_rw", mem_rw, 0);
    d_rd = resp_rdata; d_err = resp_err;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1; req_store = 1; req_funct3 = 3'b011;
      req_base = 64'h20; req_offset = 0; req_wdata = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_rdata", resp_rdata, d_rd);
      chk("hold_err", resp_err, d_err);
      chk("hold_mem_rw", mem_rw, 0);
    end
    req_valid = 0; resp_ready = 1;
    @(posedge clk); @(negedge clk);
    resp_ready = 0;
    chk("after_resp_valid", resp_valid, 0);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] base, off, wd, exp_rd;
    logic        exp_err;
    int          hold;
  } vec_t;

  function automatic vec_t mk(logic st, logic [2:0] f3, logic [63:0] base, off, wd, exp_rd,
                              logic exp_err, int hold);
    vec_t v;
    v.st = st; v.f3 = f3; v.base = base; v.off = off; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.hold = hold;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [63:0] d_rd, m_rd, exp20, got20;
    logic d_err, m_err, st;
    logic [2:0] f3;
    logic [63:0] base, off;
    int diffs;

    tbl.push_back(mk(1, 3'b011, 64'h100, 64'h8, 64'h8877665544332211, 64'h0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 64'h100, 64'h8, 64'h0, 64'h8877665544332211, 0, 1));
    tbl.push_back(mk(1, 3'b000, 64'h108, 64'h0, 64'h80, 64'h0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 64'h108, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 0));
    tbl.push_back(mk(0, 3'b100, 64'h108, 64'h0, 64'h0, 64'h80, 0, 2));
    tbl.push_back(mk(1, 3'b010, 64'h108, 64'h0, 64'h80000000, 64'h0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 64'h108, 64'h0, 64'h0, 64'hFFFFFFFF80000000, 0, 0));
    tbl.push_back(mk(0, 3'b110, 64'h108, 64'h0, 64'h0, 64'h0000000080000000, 0, 0));
    tbl.push_back(mk(1, 3'b011, 64'h1000, 64'h0, 64'hDEAD, 64'h0, 1, 0));
    tbl.push_back(mk(0, 3'b111, 64'h10, 64'h0, 64'h0, 64'h0, 1, 5));
    tbl.push_back(mk(1, 3'b010, 64'h100, 64'h0, 64'hDDCCBBAA, 64'h0, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 3'b010, 64'h102, 64'h0, 64'h0, 64'h0, 1, 0));
`else
    tbl.push_back(mk(0, 3'b010, 64'h102, 64'h0, 64'h0, 64'h000000000000DDCC, 0, 0));
`endif
    tbl.push_back(mk(1, 3'b100, 64'h40, 64'h0, 64'h1234, 64'h0, 1, 0));
    tbl.push_back(mk(0, 3'b001, 64'h10A, 64'h0, 64'h0, 64'hFFFFFFFFFFFF8000, 0, 0));
    tbl.push_back(mk(0, 3'b101, 64'h10A, 64'h0, 64'h0, 64'h8000, 0, 0));
    tbl.push_back(mk(0, 3'b011, 64'h110, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h8877665580000000, 0, 0));
    tbl.push_back(mk(0, 3'b010, 64'hFFFFFFFFFFFFFF00, 64'h200, 64'h0, 64'hFFFFFFFFDDCCBBAA, 0, 0));
    tbl.push_back(mk(0, 3'b011, 64'hFFFFFFFFFFFFFFF0, 64'h0, 64'h0, 64'h0, 1, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(1, 3'b011, 64'hFF8, 64'h4, 64'h1122334455667788, 64'h0, 1, 0));
    tbl.push_back(mk(0, 3'b011, 64'hFFC, 64'h0, 64'h0, 64'h0, 1, 0));
`else
    tbl.push_back(mk(1, 3'b011, 64'hFF8, 64'h4, 64'h1122334455667788, 64'h0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 64'hFFC, 64'h0, 64'h0, 64'h1122334455667788, 0, 0));
`endif

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    rst = 1; mem_clr = 1; req_valid = 0; resp_ready = 0; req_store = 0;
    req_funct3 = 0; req_base = 0; req_offset = 0; req_wdata = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_rw", mem_rw, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_word", mem_word, 0);
    chk("rst_mem_dataw", mem_dataw, 0);
    rst = 0; mem_clr = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      do_txn(tbl[i].st, tbl[i].f3, tbl[i].base, tbl[i].off, tbl[i].wd, tbl[i].hold,
             d_rd, d_err, m_rd, m_err);
      chk($sformatf("vec%0d_rdata", i), d_rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), d_err, tbl[i].exp_err);
    end

    // Reset during the ACCESS cycle of a store: nothing written, no response
    exp20 = '0;
    for (int i = 0; i < 8; i++) exp20[8*i +: 8] = ref_mem[32 + i];
    req_valid = 1; req_store = 1; req_funct3 = 3'b011;
    req_base = 64'h20; req_offset = 0; req_wdata = 64'hA5A5A5A5A5A5A5A5;
    @(posedge clk); @(negedge clk);
    req_valid = 0; rst = 1; #1;
    chk("abort_mem_rw", mem_rw, 0);
    @(posedge clk); @(negedge clk);
    rst = 0;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_resp_valid", resp_valid, 0);
    got20 = '0;
    for (int i = 0; i < 8; i++) got20[8*i +: 8] = mem[32 + i];
    chk("abort_mem20", got20, exp20);
    @(posedge clk); @(negedge clk);
    chk("abort_resp_valid_later", resp_valid, 0);

    for (int t = 0; t < 300; t++) begin
      st   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      base = ($urandom_range(0, 9) == 0) ? 64'($urandom_range(4000, 4300)) : 64'($urandom_range(0, 511));
      off  = 64'($signed($urandom_range(0, 64)) - 32);
      do_txn(st, f3, base, off, {$urandom, $urandom}, $urandom_range(0, 2), d_rd, d_err, m_rd, m_err);
      chk($sformatf("rnd%0d_rdata", t), d_rd, m_rd);
      chk($sformatf("rnd%0d_err", t), d_err, m_err);
    end

    diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image_diffs", 64'(diffs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store controller directly upstream of the byte-addressed data memory. It accepts one load or store request at a time from the execute stage through a valid/ready handshake and computes the effective address. It drives the memory's address, write-data, size and write-enable lines for exactly one cycle. For loads it captures the memory's combinational read data, then extracts, sign- or zero-extends and returns the result through a registered response handshake.

Parameters:
XLEN, 64, data and address width.
MEM_AW, 12, memory address width; memory size is 2**MEM_AW bytes.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_store  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3 (size/sign).
req_base  in  XLEN  base register value.
req_offset  in  XLEN  sign-extended immediate.
req_wdata  in  XLEN  store data; low bytes used.
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts response.
resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
resp_err  out  1  access error.
mem_addr  out  MEM_AW  byte address to memory.
mem_dataw  out  XLEN  write data to memory.
mem_word  out  2  size: 00 byte, 01 half, 10 word, 11 double.
mem_rw  out  1  write enable, 1 = write.
mem_datar  in  XLEN  combinational read data, little-endian from mem_addr.

Behaviour:
- States: IDLE, ACCESS, RESP. Reset forces IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_rw=0, mem_addr=0, mem_word=0, mem_dataw=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch ea = req_base + req_offset (XLEN-bit modulo add), funct3, store flag and wdata. Go to ACCESS.
- ACCESS (exactly one cycle, req_ready=0):
  - mem_addr = ea[MEM_AW-1:0]; mem_word = funct3[1:0]; mem_dataw = latched wdata.
  - mem_rw = store & ~err & ~rst, combinational, so no write lands on a reset edge.
  - For a load, capture mem_datar at the end of the cycle.
  - Go to RESP.
- err conditions:
  - ea[XLEN-1:MEM_AW] != 0 (out of range).
  - Load funct3 = 111.
  - Store funct3[2] = 1.
  - On err, no memory write occurs and resp_err=1.
- Load extraction from captured data:
  - 000: sext byte[7:0].
  - 001: sext [15:0].
  - 010: sext [31:0].
  - 011: [63:0].
  - 100, 101, 110: zero-extend 8, 16, 32 bits.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable while resp_valid=1 and resp_ready=0.
  - On resp_ready, return to IDLE. The earliest next request is accepted the cycle after.
- Latency: request accepted at edge N; memory access during cycle N+1; resp_valid high from edge N+2. Throughput is at most one request per 3 cycles.
- Outside ACCESS: mem_rw=0; mem_addr, mem_word and mem_dataw hold their last values.
- Address wrap at the top of memory (e.g. 0xFFC with a double) is passed through unmodified; the memory wraps internally. This is not an error.
- rst in any state aborts the operation: no write, no response, back to IDLE next cycle.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: ea not a multiple of the access size (2, 4 or 8 bytes for half, word, double) is an error. No write occurs; resp_err=1 and resp_rdata=0.
- Undefined: misaligned accesses proceed as byte-addressed little-endian accesses and are not an error.

Test Plan:
- Store SD base=0x100, offset=0x8, wdata=0x8877665544332211 -> mem_rw=1 for one cycle with mem_addr=0x108, mem_word=11. Then load LD at 0x108 -> resp_rdata=0x8877665544332211, resp_err=0, resp_valid two cycles after acceptance.
- With memory 0x108 = 0x80: LB -> 0xFFFFFFFFFFFFFF80; LBU -> 0x80. With 0x108..0x10B = 0x80000000: LW -> 0xFFFFFFFF80000000; LWU -> 0x0000000080000000.
- Store with base=0x1000, offset=0 -> no mem_rw pulse, resp_err=1. LD funct3=111 at 0x10 -> resp_err=1, resp_rdata=0.
- Hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stable, req_ready=0, and a new req_valid is not accepted. On resp_ready=1 -> IDLE, and the next request is accepted one cycle later.
- Assert rst during the ACCESS cycle of a store to 0x20 -> mem_rw=0 and memory at 0x20 unchanged; after reset, req_ready=1 and resp_valid=0.
- LW at 0x102: with LSU_MISALIGN_TRAP_EN -> resp_err=1 and no write; without it -> returns bytes 0x102..0x105 with resp_err=0.
